mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the CPU instruction-fetch
//  port (PC -> INST) and the load/store data port (ALU result address, rs2 write data).
//  Registered FSM: accepts one request, drives the memory for MEM_LAT cycles, returns data.
//  Data port has priority; a starvation counter guarantees fetch progress.
// PARAMETERS
//  ADDR_W      32  address width, both ports and memory
//  DATA_W      32  data width, both ports and memory
//  MEM_LAT     2   cycles memory inputs are held; >=1; mem_rdata valid on last held cycle
//  STARVE_MAX  4   consecutive data grants with if_req pending before fetch is forced; >=1
// PORTS
//  clk        in   1       clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch request; held with if_addr until if_valid
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       1-cycle pulse, fetch accepted (first ACCESS cycle)
//  if_valid   out  1       1-cycle pulse, if_rdata valid
//  if_rdata   out  DATA_W  fetched word
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_valid
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       1-cycle pulse, data accepted
//  d_valid    out  1       1-cycle pulse, load data / store ack
//  d_rdata    out  DATA_W  load data; 0 on store ack
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 when state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output 0, lat_cnt=0, starve_cnt=0.
//  - States: IDLE -> ACCESS -> DONE -> IDLE. One access per MEM_LAT+2 cycles max.
//  - IDLE: sample reqs. Winner: fetch if if_req & (~d_req | starve_cnt==STARVE_MAX),
//    else data if d_req. Winner's addr/we/wdata latched; next state ACCESS. No req: stay.
//  - ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata from latch (mem_we=0 for fetch), stable
//    for exactly MEM_LAT cycles (lat_cnt 0..MEM_LAT-1). Winner's gnt pulses on first
//    ACCESS cycle only. On last cycle mem_rdata captured; next state DONE.
//  - DONE: mem_en=mem_we=0; winner's valid=1 for this cycle, rdata = captured word
//    (d_rdata=0 for store). Requests NOT sampled in DONE; requester updates fields or drops
//    req here, new request sampled next IDLE cycle. rdata outputs hold until next DONE.
//  - starve_cnt: +1 (saturating at STARVE_MAX) on each data grant while if_req=1;
//    cleared on fetch grant or when if_req=0 in IDLE.
//  - Req inputs ignored outside IDLE; changing fields mid-access has no effect (latched).
//  - Reset mid-ACCESS/DONE: next edge forces IDLE, mem_en=0, no valid pulse, access lost.
//  - Never grant both ports; gnt/valid of the loser stay 0.
// TESTING (MEM_LAT=2, STARVE_MAX=4, memory model returns word = addr ^ 0xA5A5A5A5)
//  1 if_req=1, if_addr=0x10 at c0 -> if_gnt c1, mem_en c1-c2 addr 0x10, if_valid c3,
//    if_rdata=0xA5A5A5B5; busy c1-c3.
//  2 if_req & d_req (load 0x20) at c0 -> data served first (d_valid c3 = 0xA5A5A585),
//    fetch granted at c5, if_valid c7.
//  3 d_req held continuously + if_req held -> exactly 4 data accesses, then fetch access,
//    then data resumes; starve_cnt returns to 0 after fetch grant.
//  4 store d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1 only c1-c2 with that
//    addr/data, d_valid c3, d_rdata=0, if_* silent.
//  5 reset=1 during second ACCESS cycle -> next cycle mem_en=0, busy=0, no valid; a req
//    presented after reset is served normally.
//  6 req dropped in DONE and reasserted in IDLE with new addr 0x44 -> new access uses 0x44.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/data requesters and the unified memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and load/store.
// Data port wins ties unless fetch has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [1:0]       r_state;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [ST_W-1:0]  r_starve_cnt;
  logic             r_is_fetch;
  logic             r_we;

  logic              w_starve_full;
  logic              w_pick_fetch;
  logic              w_pick_data;
  logic              w_lat_last;
  logic              w_req_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;

  assign w_starve_full = (r_starve_cnt == ST_W'(STARVE_MAX));
  assign w_pick_fetch  = bus.if_req & (~bus.d_req | w_starve_full);
  assign w_pick_data   = ~w_pick_fetch & bus.d_req;
  assign w_lat_last    = (r_lat_cnt == LAT_W'(MEM_LAT - 1));
  assign w_req_we      = w_pick_data & bus.d_we;
  assign w_req_addr    = w_pick_fetch ? bus.if_addr : bus.d_addr;
  assign w_req_wdata   = w_pick_fetch ? '0 : bus.d_wdata;

  // The mem_* output registers double as the request latch for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lat_cnt     <= '0;
      r_starve_cnt  <= '0;
      r_is_fetch    <= 1'b0;
      r_we          <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_gnt     <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt   <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_fetch || w_pick_data) begin
            r_state       <= S_ACCESS;
            r_lat_cnt     <= '0;
            r_is_fetch    <= w_pick_fetch;
            r_we          <= w_req_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= w_req_we;
            bus.mem_addr  <= w_req_addr;
            bus.mem_wdata <= w_req_wdata;
            bus.if_gnt    <= w_pick_fetch;
            bus.d_gnt     <= w_pick_data;
            bus.busy      <= 1'b1;
          end
          if (w_pick_fetch || !bus.if_req) begin
            r_starve_cnt <= '0;
          end else if (w_pick_data && !w_starve_full) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        S_ACCESS: begin
          if (w_lat_last) begin
            r_state    <= S_DONE;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (r_is_fetch) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end else begin
              bus.d_valid <= 1'b1;
              bus.d_rdata <= r_we ? '0 : bus.mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for the corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
  localparam int SMAX = 4;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  assign bus.mem_rdata = bus.mem_addr ^ K;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  // Isolated transaction from an idle arbiter; returns at the first idle cycle afterwards.
  task automatic run_vec(input vec_t v, input string tag);
    if (v.is_data) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    chk({tag, " c0 busy"}, bus.busy, 0);
    adv();
    chk({tag, " c1 own gnt"}, v.is_data ? bus.d_gnt : bus.if_gnt, 1);
    chk({tag, " c1 other gnt"}, v.is_data ? bus.if_gnt : bus.d_gnt, 0);
    chk({tag, " c1 mem_en"}, bus.mem_en, 1);
    chk({tag, " c1 mem_we"}, bus.mem_we, v.is_data & v.we);
    chk({tag, " c1 mem_addr"}, bus.mem_addr, v.addr);
    if (v.is_data && v.we) chk({tag, " c1 mem_wdata"}, bus.mem_wdata, v.wdata);
    chk({tag, " c1 busy"}, bus.busy, 1);
    adv();
    chk({tag, " c2 own gnt"}, v.is_data ? bus.d_gnt : bus.if_gnt, 0);
    chk({tag, " c2 mem_en"}, bus.mem_en, 1);
    chk({tag, " c2 mem_we"}, bus.mem_we, v.is_data & v.we);
    chk({tag, " c2 mem_addr"}, bus.mem_addr, v.addr);
    adv();
    chk({tag, " c3 own valid"}, v.is_data ? bus.d_valid : bus.if_valid, 1);
    chk({tag, " c3 other valid"}, v.is_data ? bus.if_valid : bus.d_valid, 0);
    chk({tag, " c3 rdata"}, v.is_data ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
    chk({tag, " c3 mem_en"}, bus.mem_en, 0);
    chk({tag, " c3 mem_we"}, bus.mem_we, 0);
    chk({tag, " c3 busy"}, bus.busy, 1);
    bus.d_req = 1'b0;
    bus.if_req = 1'b0;
    adv();
    chk({tag, " c4 valid"}, bus.d_valid | bus.if_valid, 0);
    chk({tag, " c4 busy"}, bus.busy, 0);
  endtask

  // Transaction-level reference model, active only during the random phase.
  bit          model_on = 1'b0;
  bit          m_active;
  int          m_rel;
  bit          m_fetch;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_starve;
  logic [31:0] m_last_if;
  logic [31:0] m_last_d;
  int          m_fetch_grants;
  int          m_data_grants;

  always @(negedge clk) begin : model
    bit e_gif, e_gd, e_en, e_vif, e_vd, e_busy, fw, dw;
    if (model_on) begin
      e_gif = 0; e_gd = 0; e_en = 0; e_vif = 0; e_vd = 0; e_busy = 0;
      if (m_active) begin
        e_busy = 1;
        if (m_rel == 0) begin e_gif = m_fetch; e_gd = !m_fetch; end
        if (m_rel < LAT) e_en = 1;
        if (m_rel == LAT) begin
          if (m_fetch) begin e_vif = 1; m_last_if = m_addr ^ K; end
          else begin e_vd = 1; m_last_d = m_we ? 32'h0 : (m_addr ^ K); end
        end
      end
      chk("rnd if_gnt", bus.if_gnt, e_gif);
      chk("rnd d_gnt", bus.d_gnt, e_gd);
      chk("rnd mem_en", bus.mem_en, e_en);
      chk("rnd if_valid", bus.if_valid, e_vif);
      chk("rnd d_valid", bus.d_valid, e_vd);
      chk("rnd busy", bus.busy, e_busy);
      chk("rnd if_rdata", bus.if_rdata, m_last_if);
      chk("rnd d_rdata", bus.d_rdata, m_last_d);
      if (e_en) begin
        chk("rnd mem_addr", bus.mem_addr, m_addr);
        chk("rnd mem_we", bus.mem_we, m_we);
        if (m_we) chk("rnd mem_wdata", bus.mem_wdata, m_wdata);
      end else begin
        chk("rnd mem_we idle", bus.mem_we, 0);
      end
      if (m_active) begin
        if (m_rel == LAT) m_active = 0;
        else m_rel++;
      end else begin
        fw = bus.if_req && (!bus.d_req || m_starve == SMAX);
        dw = !fw && bus.d_req;
        if (fw || !bus.if_req) m_starve = 0;
        else if (dw && m_starve < SMAX) m_starve++;
        if (fw || dw) begin
          m_active = 1;
          m_rel = 0;
          m_fetch = fw;
          m_we = dw && bus.d_we;
          m_addr = fw ? bus.if_addr : bus.d_addr;
          m_wdata = bus.d_wdata;
          if (fw) m_fetch_grants++; else m_data_grants++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int exp_order[10];
    vecs[0] = '{is_data: 0, we: 0, addr: 32'h10,       wdata: 32'h0,        exp_rdata: 32'hA5A5A5B5};
    vecs[1] = '{is_data: 1, we: 0, addr: 32'h20,       wdata: 32'h0,        exp_rdata: 32'hA5A5A585};
    vecs[2] = '{is_data: 1, we: 1, addr: 32'h40,       wdata: 32'h12345678, exp_rdata: 32'h0};
    vecs[3] = '{is_data: 0, we: 0, addr: 32'hFFFFFFFF, wdata: 32'h0,        exp_rdata: 32'h5A5A5A5A};
    vecs[4] = '{is_data: 1, we: 0, addr: 32'h0,        wdata: 32'hDEADBEEF, exp_rdata: 32'hA5A5A5A5};
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) adv();
    chk("reset busy", bus.busy, 0);
    chk("reset mem_en", bus.mem_en, 0);
    chk("reset mem_we", bus.mem_we, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset gnt", {bus.if_gnt, bus.d_gnt}, 0);
    chk("reset valid", {bus.if_valid, bus.d_valid}, 0);
    chk("reset rdata", {bus.if_rdata, bus.d_rdata}, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both ports request together: data first, fetch next free slot.
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20;
    adv();
    chk("both c1 d_gnt", bus.d_gnt, 1);
    chk("both c1 if_gnt", bus.if_gnt, 0);
    adv(); adv();
    chk("both c3 d_valid", bus.d_valid, 1);
    chk("both c3 d_rdata", bus.d_rdata, 32'hA5A5A585);
    chk("both c3 if_valid", bus.if_valid, 0);
    bus.d_req = 0;
    adv();
    chk("both c4 if_gnt", bus.if_gnt, 0);
    adv();
    chk("both c5 if_gnt", bus.if_gnt, 1);
    chk("both c5 mem_addr", bus.mem_addr, 32'h100);
    chk("both c5 mem_we", bus.mem_we, 0);
    adv(); adv();
    chk("both c7 if_valid", bus.if_valid, 1);
    chk("both c7 if_rdata", bus.if_rdata, 32'hA5A5A4A5);
    bus.if_req = 0;
    adv();

    // Both held continuously: four data grants, then a forced fetch, repeating.
    bus.if_req = 1; bus.if_addr = 32'h90;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    for (int c = 1; c <= 38; c++) begin
      adv();
      if (bus.if_gnt && bus.d_gnt) chk("starve dual gnt", 1, 0);
      if (bus.d_gnt) order.push_back(0);
      if (bus.if_gnt) order.push_back(1);
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("starve grant count", order.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve grant%0d is_fetch", i), (i < order.size()) ? order[i] : 2, exp_order[i]);
    repeat (3) adv();

    // Reset during the second ACCESS cycle loses the access.
    bus.if_req = 1; bus.if_addr = 32'h30;
    adv(); adv();
    reset = 1; bus.if_req = 0;
    adv();
    chk("rst mem_en", bus.mem_en, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst if_valid", bus.if_valid, 0);
    chk("rst if_rdata", bus.if_rdata, 0);
    reset = 0;
    adv();
    chk("rst after valid", bus.if_valid | bus.d_valid, 0);
    chk("rst after busy", bus.busy, 0);
    run_vec('{is_data: 1, we: 0, addr: 32'h50, wdata: 32'h0, exp_rdata: 32'hA5A5A5F5}, "post_rst");

    // Mid-access field change ignored; drop in DONE, re-request in IDLE with new address.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    adv();
    chk("re c1 d_gnt", bus.d_gnt, 1);
    chk("re c1 mem_addr", bus.mem_addr, 32'h40);
    bus.d_addr = 32'h99;
    adv();
    chk("re c2 mem_addr held", bus.mem_addr, 32'h40);
    adv();
    chk("re c3 d_valid", bus.d_valid, 1);
    chk("re c3 d_rdata", bus.d_rdata, 32'hA5A5A5E5);
    bus.d_req = 0;
    adv();
    chk("re c4 busy", bus.busy, 0);
    bus.d_req = 1; bus.d_addr = 32'h44;
    adv();
    chk("re c5 d_gnt", bus.d_gnt, 1);
    chk("re c5 mem_addr", bus.mem_addr, 32'h44);
    adv(); adv();
    chk("re c7 d_valid", bus.d_valid, 1);
    chk("re c7 d_rdata", bus.d_rdata, 32'hA5A5A5E1);
    bus.d_req = 0;
    adv();

    // Randomized traffic against the reference model.
    reset = 1;
    adv(); adv();
    m_active = 0; m_rel = 0; m_starve = 0; m_last_if = '0; m_last_d = '0;
    m_fetch = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_fetch_grants = 0; m_data_grants = 0;
    reset = 0;
    model_on = 1;
    for (int t = 0; t < 3000; t++) begin
      adv();
      if (bus.if_req) begin
        if (bus.if_valid) begin
          if ($urandom_range(1, 0) == 1) bus.if_req = 0;
          else bus.if_addr = $urandom;
        end
      end else if ($urandom_range(99, 0) < 40) begin
        bus.if_req = 1; bus.if_addr = $urandom;
      end
      if (bus.d_req) begin
        if (bus.d_valid) begin
          if ($urandom_range(3, 0) == 0) bus.d_req = 0;
          else begin bus.d_we = 1'($urandom_range(1, 0)); bus.d_addr = $urandom; bus.d_wdata = $urandom; end
        end
      end else if ($urandom_range(99, 0) < 70) begin
        bus.d_req = 1; bus.d_we = 1'($urandom_range(1, 0)); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
    end
    bus.if_req = 0; bus.d_req = 0;
    repeat (6) adv();
    model_on = 0;
    chk("rnd fetch grants seen", m_fetch_grants > 0, 1);
    chk("rnd data grants seen", m_data_grants > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
